// File: rtl/wb_trace_buffer.sv
// ---------------------------------------------------------------------------
// wb_trace_buffer
//
// Commit trace buffer for the mips pipeline. Every register-file write
// committed in W and every data-memory write committed in M becomes one
// 97-bit record {kind, pc, addr, data}. Records are held in program order in
// a circular FIFO and drained over a valid/ready handshake. Events that find
// no room are dropped and counted.
//
// Ports
//   clk, reset       single clock; synchronous active-low reset
//   grf_we/pc/addr/wdata   register-file write event (kind = 0)
//   dm_we/pc/addr/wdata    data-memory write event   (kind = 1)
//   trace_valid      head record available
//   trace_ready      sink accepts the head record
//   trace_data       head record {kind, pc[31:0], addr[31:0], data[31:0]}
//   overflow         sticky: at least one event dropped since reset
//   drop_cnt         saturating count of dropped events
// ---------------------------------------------------------------------------
module wb_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             grf_we,
   input  logic [31:0]      grf_pc,
   input  logic [4:0]       grf_addr,
   input  logic [31:0]      grf_wdata,
   input  logic             dm_we,
   input  logic [31:0]      dm_pc,
   input  logic [31:0]      dm_addr,
   input  logic [31:0]      dm_wdata,
   output logic             trace_valid,
   input  logic             trace_ready,
   output logic [96:0]      trace_data,
   output logic             overflow,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int AW    = $clog2(DEPTH);
   localparam int REC_W = 97;

   logic [REC_W-1:0] mem [DEPTH];

   logic [AW-1:0]    wp_reg, wp_next;
   logic [AW-1:0]    rp_reg, rp_next;
   logic [AW:0]      cnt_reg, cnt_next;
   logic             overflow_reg, overflow_next;
   logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

   logic             pop;
   logic [AW+1:0]    free;
   logic             push_grf, push_dm;
   logic [1:0]       pushed, dropped;
   logic [CNT_W:0]   drop_sum;
   logic [AW-1:0]    wp_plus1;
   logic             first_we, second_we;
   logic [REC_W-1:0] grf_rec, dm_rec, first_rec;

   assign grf_rec = {1'b0, grf_pc, 27'b0, grf_addr, grf_wdata};
   assign dm_rec  = {1'b1, dm_pc, dm_addr, dm_wdata};

   always_comb begin
      pop  = (cnt_reg != '0) && trace_ready;
      // A slot released by this cycle's pop is reusable by this cycle's push.
      free = (AW+2)'(DEPTH) - (AW+2)'(cnt_reg) + (AW+2)'(pop);

      // GRF is the older instruction, so it claims the first free slot.
      push_grf = grf_we && (free != '0);
      push_dm  = dm_we && ((free > (AW+2)'(1)) || (!grf_we && (free != '0)));

      pushed  = {1'b0, push_grf} + {1'b0, push_dm};
      dropped = {1'b0, grf_we & ~push_grf} + {1'b0, dm_we & ~push_dm};

      // Whichever record is enqueued alone lands at wp; a pair spans wp, wp+1.
      first_we  = push_grf | push_dm;
      first_rec = push_grf ? grf_rec : dm_rec;
      second_we = push_grf & push_dm;
      wp_plus1  = wp_reg + AW'(1);

      wp_next  = wp_reg + AW'(pushed);
      rp_next  = rp_reg + AW'(pop);
      cnt_next = cnt_reg + (AW+1)'(pushed) - (AW+1)'(pop);

      overflow_next = overflow_reg | (dropped != 2'd0);
      drop_sum      = {1'b0, drop_cnt_reg} + (CNT_W+1)'(dropped);
      drop_cnt_next = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   // Storage is plain array state: never cleared, written only outside reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (first_we)
            mem[wp_reg] <= first_rec;
         if (second_we)
            mem[wp_plus1] <= dm_rec;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wp_reg       <= '0;
         rp_reg       <= '0;
         cnt_reg      <= '0;
         overflow_reg <= 1'b0;
         drop_cnt_reg <= '0;
      end else begin
         wp_reg       <= wp_next;
         rp_reg       <= rp_next;
         cnt_reg      <= cnt_next;
         overflow_reg <= overflow_next;
         drop_cnt_reg <= drop_cnt_next;
      end
   end

   assign trace_valid = (cnt_reg != '0);
   assign trace_data  = mem[rp_reg];
   assign overflow    = overflow_reg;
   assign drop_cnt    = drop_cnt_reg;

endmodule
